// File: rtl/echo_indication_fifo.sv
`default_nettype none
// ============================================================================
// Module   : echo_indication_fifo
// Purpose  : Buffers fifoenq values in a DEPTH-entry FIFO. The head entry is
//            held for ECHO_DELAY cycles and then issued on the heard
//            indication. Values are echoed in strict FIFO order.
// Revision : 1.0 - initial release
// ============================================================================
module echo_indication_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int ECHO_DELAY = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     fifoenq__ENA,
  input  logic [WIDTH-1:0]         fifoenq_v,
  output logic                     fifoenq__RDY,
  output logic                     heard__ENA,
  output logic [WIDTH-1:0]         heard_v,
  input  logic                     heard__RDY,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              echo_count
);

  localparam int                  c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]       c_FULL     = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]       c_OCC_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW-1:0]     c_PTR_ONE  = c_AW'(1);
  localparam logic [7:0]          c_DELAY    = 8'(ECHO_DELAY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_occ;
  logic [7:0]       r_dcnt;
  logic [15:0]      r_echo_count;
  state_t           r_state;

  logic             w_enq;
  logic             w_deq;

  // Full/empty come only from the occupancy count; the guard never looks at
  // the dequeue side, so a same-cycle heard cannot open room for an enqueue.
  assign fifoenq__RDY = (r_occ != c_FULL);
  assign w_enq        = fifoenq__ENA & fifoenq__RDY;
  assign w_deq        = (r_state == SEND) & heard__RDY;
  assign heard__ENA   = w_deq;
  assign heard_v      = r_mem[r_rd_ptr];
  assign occupancy    = r_occ;
  assign echo_count   = r_echo_count;

  // Storage array: written on accepted enqueues, never reset (contents are
  // only observed through rd_ptr while occupancy is non-zero).
  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= fifoenq_v;
    end
  end

  // Pointers, occupancy and completed-echo counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_echo_count <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_deq) begin
        r_rd_ptr     <= r_rd_ptr + c_PTR_ONE;
        r_echo_count <= r_echo_count + 16'd1;
      end
      if (w_enq && !w_deq) begin
        r_occ <= r_occ + c_OCC_ONE;
      end else if (w_deq && !w_enq) begin
        r_occ <= r_occ - c_OCC_ONE;
      end
    end
  end

  // Echo sequencer: IDLE notices a buffered head, WAIT holds it for the
  // configured delay, SEND offers it until the sink takes it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_dcnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_occ != '0) begin
            if (c_DELAY != 8'd0) begin
              r_state <= WAIT;
              r_dcnt  <= c_DELAY;
            end else begin
              r_state <= SEND;
            end
          end
        end
        WAIT: begin
          r_dcnt <= r_dcnt - 8'd1;
          if (r_dcnt == 8'd1) begin
            r_state <= SEND;
          end
        end
        SEND: begin
          if (heard__RDY) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_echo_indication_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_echo_indication_fifo
// Purpose  : Scoreboard bench for echo_indication_fifo. Two instances: one
//            with no echo delay, one with a 3-cycle echo delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_echo_indication_fifo;

  typedef struct {
    logic [31:0] val;
    int          cyc;   // required output cycle, or -1 when timing is free
  } exp_t;

  logic        CLK = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  exp_t        q0[$];
  exp_t        q3[$];
  exp_t        e0;
  exp_t        e3;

  // Instance 0: ECHO_DELAY = 0
  logic        rst0, ena0, rdy0, hena0, hrdy0;
  logic [31:0] v0, hv0;
  logic [2:0]  occ0;
  logic [15:0] ecnt0;

  // Instance 3: ECHO_DELAY = 3
  logic        rst3, ena3, rdy3, hena3, hrdy3;
  logic [31:0] v3, hv3;
  logic [2:0]  occ3;
  logic [15:0] ecnt3;

  echo_indication_fifo #(.WIDTH(32), .DEPTH(4), .ECHO_DELAY(0)) u_d0 (
    .CLK(CLK), .RST(rst0),
    .fifoenq__ENA(ena0), .fifoenq_v(v0), .fifoenq__RDY(rdy0),
    .heard__ENA(hena0), .heard_v(hv0), .heard__RDY(hrdy0),
    .occupancy(occ0), .echo_count(ecnt0)
  );

  echo_indication_fifo #(.WIDTH(32), .DEPTH(4), .ECHO_DELAY(3)) u_d3 (
    .CLK(CLK), .RST(rst3),
    .fifoenq__ENA(ena3), .fifoenq_v(v3), .fifoenq__RDY(rdy3),
    .heard__ENA(hena3), .heard_v(hv3), .heard__RDY(hrdy3),
    .occupancy(occ3), .echo_count(ecnt3)
  );

  // 10 ns clock
  always #5 CLK = ~CLK;

  // Cycle index: cycle N is the interval after the N-th rising edge
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push0(input int val, input int when);
    exp_t e;
    e.val = val;
    e.cyc = when;
    q0.push_back(e);
  endtask

  task automatic push3(input int val, input int when);
    exp_t e;
    e.val = val;
    e.cyc = when;
    q3.push_back(e);
  endtask

  // Monitor for instance 0: every heard call must match the queue head
  always @(negedge CLK) begin
    if (hena0) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL d0_unexpected_heard: got heard_v=%0d at cycle %0d, expected no heard__ENA", hv0, cyc);
      end else begin
        e0 = q0.pop_front();
        chk("d0_heard_v", hv0, e0.val);
        if (e0.cyc >= 0) chk("d0_heard_cycle", cyc, e0.cyc);
      end
    end
  end

  // Monitor for instance 3
  always @(negedge CLK) begin
    if (hena3) begin
      if (q3.size() == 0) begin
        n_checks++;
        $display("FAIL d3_unexpected_heard: got heard_v=%0d at cycle %0d, expected no heard__ENA", hv3, cyc);
      end else begin
        e3 = q3.pop_front();
        chk("d3_heard_v", hv3, e3.val);
        if (e3.cyc >= 0) chk("d3_heard_cycle", cyc, e3.cyc);
      end
    end
  end

  initial begin
    int t;
    rst0 = 1'b1; ena0 = 1'b0; v0 = '0; hrdy0 = 1'b1;
    rst3 = 1'b1; ena3 = 1'b0; v3 = '0; hrdy3 = 1'b1;

    // T1: reset for 2 cycles, then idle
    tick();
    tick();
    rst0 = 1'b0;
    rst3 = 1'b0;
    @(negedge CLK);
    chk("t1_rdy0", rdy0, 1);
    chk("t1_hena0", hena0, 0);
    chk("t1_occ0", occ0, 0);
    chk("t1_ecnt0", ecnt0, 0);
    chk("t1_rdy3", rdy3, 1);
    chk("t1_occ3", occ3, 0);
    chk("t1_ecnt3", ecnt3, 0);

    // T2 (delay 0) and T3 (delay 3): enq 22 in cycle t
    tick();
    t = cyc;
    ena0 = 1'b1; v0 = 32'd22; push0(22, t + 2);
    ena3 = 1'b1; v3 = 32'd22; push3(22, t + 5);
    tick();
    ena0 = 1'b0;
    ena3 = 1'b0;
    repeat (10) tick();
    @(negedge CLK);
    chk("t2_ecnt0", ecnt0, 1);
    chk("t2_occ0", occ0, 0);
    chk("t3_ecnt3", ecnt3, 1);
    chk("t3_q3_drained", q3.size(), 0);

    // Clear instance 0 before the fill test
    tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    @(negedge CLK);
    chk("rst_ecnt0", ecnt0, 0);

    // T4: sink stalled, offer 1..5 back to back; only 1..4 fit
    hrdy0 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      ena0 = 1'b1;
      v0 = i;
      if (i <= 4) push0(i, -1);
      @(negedge CLK);
      chk("t4_rdy_before_enq", rdy0, (i <= 4) ? 1 : 0);
    end
    tick();
    ena0 = 1'b0;
    @(negedge CLK);
    chk("t4_occ_full", occ0, 4);
    chk("t4_rdy_full", rdy0, 0);
    hrdy0 = 1'b1;
    repeat (12) tick();
    @(negedge CLK);
    chk("t4_ecnt0", ecnt0, 4);
    chk("t4_occ_empty", occ0, 0);

    // T5: full FIFO, heard fires while enq is held
    hrdy0 = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      tick();
      ena0 = 1'b1;
      v0 = i;
      push0(i, -1);
    end
    tick();
    ena0 = 1'b0;
    repeat (2) tick();
    ena0 = 1'b1; v0 = 32'd14; hrdy0 = 1'b1;
    @(negedge CLK);
    chk("t5_rdy_at_fire", rdy0, 0);
    chk("t5_hena_at_fire", hena0, 1);
    chk("t5_occ_at_fire", occ0, 4);
    tick();
    hrdy0 = 1'b0;
    push0(14, -1);
    @(negedge CLK);
    chk("t5_occ_after_fire", occ0, 3);
    chk("t5_rdy_after_fire", rdy0, 1);
    tick();
    ena0 = 1'b0;
    @(negedge CLK);
    chk("t5_occ_refilled", occ0, 4);
    hrdy0 = 1'b1;
    repeat (20) tick();
    @(negedge CLK);
    chk("t5_occ_empty", occ0, 0);
    chk("t5_ecnt0", ecnt0, 9);

    // T6: reset instance 3 while it waits with 3 entries buffered
    hrdy3 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      ena3 = 1'b1;
      v3 = i;
    end
    tick();
    ena3 = 1'b0;
    rst3 = 1'b1;
    @(negedge CLK);
    chk("t6_occ_before_rst", occ3, 3);
    chk("t6_hena_in_wait", hena3, 0);
    tick();
    rst3 = 1'b0;
    @(negedge CLK);
    chk("t6_occ_after_rst", occ3, 0);
    chk("t6_ecnt_after_rst", ecnt3, 0);
    chk("t6_rdy_after_rst", rdy3, 1);
    repeat (12) tick();
    @(negedge CLK);
    chk("t6_occ_stays_empty", occ3, 0);
    chk("t6_ecnt_stays_zero", ecnt3, 0);

    // Every expected echo must have appeared
    chk("end_q0_drained", q0.size(), 0);
    chk("end_q3_drained", q3.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
